video_sampler_stream: RTL



---
 rtl/video_sampler_stream.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/video_sampler_stream.sv
// video_sampler_stream: camera bus sampler that packs, crops and streams frames as Avalon-ST packets
module video_sampler_stream #(
  parameter int PIXEL_W         = 8,
  parameter int BYTES_PER_PIXEL = 2,
  parameter int CNT_W           = 12,
  parameter int FIFO_DEPTH      = 16,
  parameter bit VSYNC_POL       = 1'b1
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 pclk_i,
  input  logic                                 href_i,
  input  logic                                 vsync_i,
  input  logic [PIXEL_W-1:0]                   pixel_i,
  input  logic                                 enable,
  input  logic [CNT_W-1:0]                     x_start,
  input  logic [CNT_W-1:0]                     x_end,
  input  logic [CNT_W-1:0]                     y_start,
  input  logic [CNT_W-1:0]                     y_end,
  input  logic                                 clear_status,
  output logic [PIXEL_W*BYTES_PER_PIXEL-1:0]   st_data,
  output logic                                 st_valid,
  output logic                                 st_sop,
  output logic                                 st_eop,
  input  logic                                 st_ready,
  output logic                                 overflow,
  output logic                                 frame_err,
  output logic [15:0]                          frame_count
);
  localparam int OUT_W = PIXEL_W * BYTES_PER_PIXEL;
  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PW = (BYTES_PER_PIXEL > 2) ? $clog2(BYTES_PER_PIXEL) : 1;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACTIVE, S_DROP} state_t;
  logic [PIXEL_W+2:0] s1, s2;
  logic pclk_d, href_d, vsync_d, strobe_e, hrise_e, hfall_e, fs_e;
  logic [PIXEL_W-1:0] byte_e;
  logic [PW-1:0] phase, ph;
  logic last_b, pix_v, fs_p, sop_pend;
  logic [OUT_W-1:0] sh;
  logic [OUT_W+PIXEL_W-1:0] cat;
  logic [CNT_W-1:0] x, y, px, py, wxs, wxe, wys, wye;
  logic keep, eop_k, wr, rd, full, ovf_set, err_set;
  state_t st, nxt;
  logic [OUT_W+1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  assign ph = hrise_e ? '0 : phase;
  assign last_b = ph == PW'(BYTES_PER_PIXEL - 1);
  assign cat = {sh, byte_e};
  assign keep = pix_v && px >= wxs && px <= wxe && py >= wys && py <= wye;
  assign eop_k = keep && px == wxe && py == wye;
  assign full = cnt == (AW+1)'(FIFO_DEPTH);
  assign st_valid = cnt != '0;
  assign rd = st_valid & st_ready;
  assign {st_sop, st_eop, st_data} = st_valid ? mem[rp] : '0;
  // two-flop synchronisers for every camera input, then edge detection
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
      {pclk_d, href_d, vsync_d} <= '0;
      {strobe_e, hrise_e, hfall_e, fs_e} <= '0;
      byte_e <= '0;
    end else begin
      s1 <= {pclk_i, href_i, vsync_i, pixel_i};
      s2 <= s1;
      {pclk_d, href_d, vsync_d} <= s2[PIXEL_W+2:PIXEL_W];
      strobe_e <= s2[PIXEL_W+2] & ~pclk_d & s2[PIXEL_W+1];
      hrise_e <= s2[PIXEL_W+1] & ~href_d;
      hfall_e <= ~s2[PIXEL_W+1] & href_d;
      fs_e <= (s2[PIXEL_W] == VSYNC_POL) && (vsync_d != VSYNC_POL);
      byte_e <= s2[PIXEL_W-1:0];
    end
  // byte packing, pixel coordinates and per-frame window latch
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      phase <= '0;
      sh <= '0;
      pix_v <= 1'b0;
      fs_p <= 1'b0;
      {x, y, px, py, wxs, wxe, wys, wye} <= '0;
    end else begin
      pix_v <= strobe_e & last_b;
      fs_p <= fs_e;
      phase <= (hfall_e || (strobe_e && last_b)) ? '0 : strobe_e ? ph + 1'b1 : ph;
      if (strobe_e) sh <= cat[OUT_W-1:0];
      if (fs_e) begin
        x <= '0;
        y <= '0;
        {wxs, wxe, wys, wye} <= {x_start, x_end, y_start, y_end};
      end else if (hfall_e) begin
        x <= '0;
        y <= y + 1'b1;
      end else if (strobe_e && last_b) begin
        px <= x;
        py <= y;
        x <= x + 1'b1;
      end
    end
  // capture state, sticky flags and completed-frame counter
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      st <= S_IDLE;
      sop_pend <= 1'b0;
      overflow <= 1'b0;
      frame_err <= 1'b0;
      frame_count <= '0;
    end else begin
      st <= nxt;
      sop_pend <= fs_p | (sop_pend & ~wr);
      overflow <= ovf_set | (overflow & ~clear_status);
      frame_err <= err_set | (frame_err & ~clear_status);
      frame_count <= frame_count + 16'(wr & eop_k);
    end
  // next state and write decision; a full FIFO drops the rest of the frame
  always_comb begin
    nxt = st;
    wr = 1'b0;
    ovf_set = 1'b0;
    err_set = 1'b0;
    case (st)
      S_IDLE: nxt = enable ? S_WAIT : S_IDLE;
      S_WAIT: nxt = fs_p ? S_ACTIVE : S_WAIT;
      S_ACTIVE:
        if (fs_p) begin
          err_set = 1'b1;
          nxt = enable ? S_ACTIVE : S_IDLE;
        end else if (keep && full) begin
          ovf_set = 1'b1;
          nxt = S_DROP;
        end else if (keep) begin
          wr = 1'b1;
          nxt = eop_k ? (enable ? S_WAIT : S_IDLE) : S_ACTIVE;
        end
      S_DROP: nxt = fs_p ? (enable ? S_ACTIVE : S_IDLE) : S_DROP;
      default: nxt = S_IDLE;
    endcase
  end
  // FIFO storage carries sop/eop alongside the pixel word
  always_ff @(posedge clk)
    if (wr) mem[wp] <= {sop_pend, eop_k, sh};
  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
endmodule
